// File: rtl/fp_mul_pipe.sv
// Pipelined IEEE-754-style multiplier: flush-to-zero inputs, round-to-nearest-even,
// valid/ready handshake with whole-pipeline freeze on output stall.
module fp_mul_pipe #(
    parameter int EXP_W  = 8,
    parameter int MAN_W  = 23,
    parameter int STAGES = 2,
    parameter int TAG_W  = 4
) (
    input  logic                       clk,
    input  logic                       rst,
    input  logic                       in_valid,
    output logic                       in_ready,
    input  logic [1+EXP_W+MAN_W-1:0]   in_a,
    input  logic [1+EXP_W+MAN_W-1:0]   in_b,
    input  logic [TAG_W-1:0]           in_tag,
    output logic                       out_valid,
    input  logic                       out_ready,
    output logic [1+EXP_W+MAN_W-1:0]   out_result,
    output logic [TAG_W-1:0]           out_tag,
    output logic [3:0]                 out_flags
);

    localparam int W    = 1 + EXP_W + MAN_W;
    localparam int BIAS = (1 << (EXP_W - 1)) - 1;
    localparam int SW   = MAN_W + 1;
    localparam int PW   = 2 * SW;
    localparam int EW   = EXP_W + 2;
    localparam logic signed [EW-1:0] EXP_MAX = EW'((1 << EXP_W) - 1);

    typedef struct packed {
        logic [W-1:0]     result;
        logic [TAG_W-1:0] tag;
        logic [3:0]       flags;   // {NV, OF, UF, NX}
    } stage_t;

    function automatic stage_t mul_op(input logic [W-1:0] a, input logic [W-1:0] b,
                                      input logic [TAG_W-1:0] tag);
        stage_t             r;
        logic               sign;
        logic [EXP_W-1:0]   ea, eb, ones;
        logic [MAN_W-1:0]   ma, mb, man;
        logic               a_nan, b_nan, a_inf, b_inf, a_zero, b_zero;
        logic [PW-1:0]      prod, norm;
        logic [SW-1:0]      sig;
        logic [SW:0]        rnd;
        logic               g, rb, st, up, carry, inexact;
        logic signed [EW-1:0] e;
        logic [W-1:0]       qnan;

        ea     = a[W-2 -: EXP_W];
        eb     = b[W-2 -: EXP_W];
        ma     = a[MAN_W-1:0];
        mb     = b[MAN_W-1:0];
        ones   = '1;
        sign   = a[W-1] ^ b[W-1];
        a_nan  = (ea == ones) && (ma != '0);
        b_nan  = (eb == ones) && (mb != '0);
        a_inf  = (ea == ones) && (ma == '0);
        b_inf  = (eb == ones) && (mb == '0);
        a_zero = (ea == '0);
        b_zero = (eb == '0);
        qnan   = {1'b0, ones, 1'b1, {(MAN_W-1){1'b0}}};

        prod    = PW'({1'b1, ma}) * PW'({1'b1, mb});
        norm    = prod[PW-1] ? prod : (prod << 1);
        sig     = norm[PW-1 -: SW];
        g       = norm[PW-1-SW];
        rb      = norm[PW-2-SW];
        st      = |norm[PW-3-SW:0];
        up      = g & (rb | st | sig[0]);
        rnd     = {1'b0, sig} + (SW+1)'(up);
        carry   = rnd[SW];
        man     = carry ? rnd[MAN_W:1] : rnd[MAN_W-1:0];
        inexact = g | rb | st;
        // Signed and two bits wider than the field so neither overflow nor underflow can wrap.
        e = EW'(ea) + EW'(eb) - EW'(BIAS) + EW'(prod[PW-1]) + EW'(carry);

        r.tag    = tag;
        r.flags  = '0;
        r.result = '0;
        if (a_nan || b_nan) begin
            r.result   = qnan;
            r.flags[3] = (a_nan && !ma[MAN_W-1]) || (b_nan && !mb[MAN_W-1]);
        end else if ((a_inf && b_zero) || (b_inf && a_zero)) begin
            r.result   = qnan;
            r.flags[3] = 1'b1;
        end else if (a_inf || b_inf) begin
            r.result = {sign, ones, {MAN_W{1'b0}}};
        end else if (a_zero || b_zero) begin
            r.result = {sign, {(W-1){1'b0}}};
        end else if (e >= EXP_MAX) begin
            r.result = {sign, ones, {MAN_W{1'b0}}};
            r.flags  = 4'b0101;
        end else if (e <= 0) begin
            r.result = {sign, {(W-1){1'b0}}};
            r.flags  = 4'b0011;
        end else begin
            r.result   = {sign, e[EXP_W-1:0], man};
            r.flags[0] = inexact;
        end
        return r;
    endfunction

    logic [STAGES-1:0] valid_q, valid_d;
    stage_t            data_q [STAGES];
    stage_t            data_d [STAGES];
    logic              stall;

    assign stall      = valid_q[STAGES-1] && !out_ready;
    assign in_ready   = !stall;
    assign out_valid  = valid_q[STAGES-1];
    assign out_result = data_q[STAGES-1].result;
    assign out_tag    = data_q[STAGES-1].tag;
    assign out_flags  = data_q[STAGES-1].flags;

    // NOTE: every output of this block is assigned a hold value first, so no latch can form.
    always_comb begin
        valid_d = valid_q;
        data_d  = data_q;
        if (!stall) begin
            valid_d[0] = in_valid;
            data_d[0]  = mul_op(in_a, in_b, in_tag);
            for (int i = 1; i < STAGES; i++) begin
                valid_d[i] = valid_q[i-1];
                data_d[i]  = data_q[i-1];
            end
        end
    end

    // NOTE: state uses non-blocking assignments so all stages shift from the same pre-edge values.
    always_ff @(posedge clk) begin
        if (rst) begin
            valid_q <= '0;
            // NOTE: data stages are reset too, since the output fields must read zero after reset.
            for (int i = 0; i < STAGES; i++) data_q[i] <= '0;
        end else begin
            valid_q <= valid_d;
            data_q  <= data_d;
        end
    end

endmodule

// File: tb/tb_fp_mul_pipe.sv
// Directed bench for fp_mul_pipe: FP32 with STAGES=2 and 3, FP16 with STAGES=1.
module tb_fp_mul_pipe;

    logic clk = 1'b0;
    logic rst = 1'b1;
    always #5 clk = ~clk;

    int total = 0;
    int bad   = 0;

    // FP32, STAGES=2
    logic        v32 = 0, r32, ov32, or32 = 1;
    logic [31:0] a32 = 0, b32 = 0, res32;
    logic [3:0]  t32 = 0, tag32, fl32;

    // FP32, STAGES=3 (backpressure / reset)
    logic        vb = 0, rb, ovb, orb = 1;
    logic [31:0] ab = 0, bb = 0, resb;
    logic [3:0]  tb = 0, tagb, flb;

    // FP16, STAGES=1
    logic        v16 = 0, r16, ov16, or16 = 1;
    logic [15:0] a16 = 0, b16 = 0, res16;
    logic [3:0]  t16 = 0, tag16, fl16;

    fp_mul_pipe #(.EXP_W(8), .MAN_W(23), .STAGES(2), .TAG_W(4)) u_fp32 (
        .clk(clk), .rst(rst), .in_valid(v32), .in_ready(r32), .in_a(a32), .in_b(b32),
        .in_tag(t32), .out_valid(ov32), .out_ready(or32), .out_result(res32),
        .out_tag(tag32), .out_flags(fl32));

    fp_mul_pipe #(.EXP_W(8), .MAN_W(23), .STAGES(3), .TAG_W(4)) u_bp (
        .clk(clk), .rst(rst), .in_valid(vb), .in_ready(rb), .in_a(ab), .in_b(bb),
        .in_tag(tb), .out_valid(ovb), .out_ready(orb), .out_result(resb),
        .out_tag(tagb), .out_flags(flb));

    fp_mul_pipe #(.EXP_W(5), .MAN_W(10), .STAGES(1), .TAG_W(4)) u_fp16 (
        .clk(clk), .rst(rst), .in_valid(v16), .in_ready(r16), .in_a(a16), .in_b(b16),
        .in_tag(t16), .out_valid(ov16), .out_ready(or16), .out_result(res16),
        .out_tag(tag16), .out_flags(fl16));

    // Issues one op on u_fp32 and reports what appears exactly two cycles later.
    task automatic issue32(input logic [31:0] a, input logic [31:0] b, input logic [3:0] tag,
                           output logic [31:0] res, output logic [3:0] fl, output logic [3:0] tg,
                           output bit lat_ok);
        bit acc, early;
        @(negedge clk);
        a32 = a; b32 = b; t32 = tag; v32 = 1;
        acc = r32;
        @(posedge clk);
        @(negedge clk);
        v32 = 0;
        early = ov32;
        @(posedge clk);
        @(negedge clk);
        lat_ok = acc && !early && (ov32 === 1'b1);
        res = res32; fl = fl32; tg = tag32;
    endtask

    task automatic issue16(input logic [15:0] a, input logic [15:0] b,
                           output logic [15:0] res, output logic [3:0] fl, output bit lat_ok);
        bit acc;
        @(negedge clk);
        a16 = a; b16 = b; t16 = 4'h3; v16 = 1;
        acc = r16;
        @(posedge clk);
        @(negedge clk);
        v16 = 0;
        lat_ok = acc && (ov16 === 1'b1);
        res = res16; fl = fl16;
    endtask

    task automatic test_reset;
        total += 1;
        if (ov32 !== 1'b0 || res32 !== 32'h0 || tag32 !== 4'h0 || fl32 !== 4'h0 || r32 !== 1'b1) begin
            bad += 1;
            $display("FAIL reset_state: got valid=%b res=%h tag=%h flags=%b ready=%b, want 0 0 0 0 1",
                     ov32, res32, tag32, fl32, r32);
        end
        total += 1;
        if (ovb !== 1'b0 || rb !== 1'b1 || ov16 !== 1'b0 || r16 !== 1'b1) begin
            bad += 1;
            $display("FAIL reset_state_other: got bp v=%b r=%b fp16 v=%b r=%b, want 0 1 0 1",
                     ovb, rb, ov16, r16);
        end
    endtask

    // Runs a table of FP32 vectors through u_fp32 with latency, result, flag and tag checks.
    task automatic run_table32(input string name, input logic [31:0] va [], input logic [31:0] vb_ [],
                               input logic [31:0] vr [], input logic [3:0] vf []);
        logic [31:0] res;
        logic [3:0]  fl, tg;
        bit          lat_ok;
        for (int i = 0; i < va.size(); i++) begin
            issue32(va[i], vb_[i], 4'(i + 5), res, fl, tg, lat_ok);
            total += 1;
            if (!lat_ok) begin
                bad += 1;
                $display("FAIL %s[%0d] latency: result not valid exactly 2 cycles after accept", name, i);
            end
            total += 1;
            if (res !== vr[i] || tg !== 4'(i + 5)) begin
                bad += 1;
                $display("FAIL %s[%0d] result: got %h tag %h, want %h tag %h", name, i, res, tg, vr[i], 4'(i + 5));
            end
            total += 1;
            if (fl !== vf[i]) begin
                bad += 1;
                $display("FAIL %s[%0d] flags: got %b, want %b", name, i, fl, vf[i]);
            end
        end
    endtask

    task automatic test_basics;
        logic [31:0] va [] = '{32'h3FC00000, 32'h3F800000};
        logic [31:0] vb_ [] = '{32'h40000000, 32'hBF800000};
        logic [31:0] vr [] = '{32'h40400000, 32'hBF800000};
        logic [3:0]  vf [] = '{4'b0000, 4'b0000};
        run_table32("basic", va, vb_, vr, vf);
    endtask

    task automatic test_rounding;
        logic [31:0] va [] = '{32'h3F800001, 32'h3F800800};
        logic [31:0] vb_ [] = '{32'h3F800001, 32'h3F800800};
        logic [31:0] vr [] = '{32'h3F800002, 32'h3F801000};
        logic [3:0]  vf [] = '{4'b0001, 4'b0001};
        run_table32("round", va, vb_, vr, vf);
    endtask

    task automatic test_exceptions;
        logic [31:0] va [] = '{32'h7F7FFFFF, 32'h7F800000, 32'h7F800001, 32'h00800000,
                               32'hFF800000, 32'h80000000, 32'h7FC00000};
        logic [31:0] vb_ [] = '{32'h40000000, 32'h00000000, 32'h3F800000, 32'h3F000000,
                               32'h40000000, 32'h3F800000, 32'h3F800000};
        logic [31:0] vr [] = '{32'h7F800000, 32'h7FC00000, 32'h7FC00000, 32'h00000000,
                               32'hFF800000, 32'h80000000, 32'h7FC00000};
        logic [3:0]  vf [] = '{4'b0101, 4'b1000, 4'b1000, 4'b0011,
                               4'b0000, 4'b0000, 4'b0000};
        run_table32("exc", va, vb_, vr, vf);
    endtask

    task automatic test_back_to_back;
        logic [31:0] va [3] = '{32'h3FC00000, 32'h3F800000, 32'h40000000};
        logic [31:0] vb_ [3] = '{32'h40000000, 32'hBF800000, 32'h40000000};
        logic [31:0] vr [3] = '{32'h40400000, 32'hBF800000, 32'h40800000};
        for (int c = 0; c < 6; c++) begin
            @(negedge clk);
            if (c < 3) begin
                v32 = 1; a32 = va[c]; b32 = vb_[c]; t32 = 4'(c + 1);
            end else begin
                v32 = 0;
            end
            total += 1;
            if (c >= 2 && c <= 4) begin
                if (ov32 !== 1'b1 || tag32 !== 4'(c - 1) || res32 !== vr[c-2]) begin
                    bad += 1;
                    $display("FAIL b2b cycle %0d: got v=%b tag=%h res=%h, want 1 %h %h",
                             c, ov32, tag32, res32, 4'(c - 1), vr[c-2]);
                end
            end else if (ov32 !== 1'b0) begin
                bad += 1;
                $display("FAIL b2b cycle %0d: got out_valid=%b, want 0", c, ov32);
            end
        end
    endtask

    task automatic test_backpressure;
        logic [31:0] bv [5] = '{32'h40000000, 32'h40400000, 32'h40800000, 32'h40A00000, 32'h40C00000};
        int sent = 0;
        int got  = 0;
        bit rdy;
        for (int c = 0; c < 40; c++) begin
            @(negedge clk);
            orb = (c >= 8);
            vb  = (sent < 5);
            ab  = 32'h3F800000;
            bb  = bv[(sent < 5) ? sent : 0];
            tb  = 4'(sent + 1);
            #1;
            rdy = rb;
            if (c >= 3 && c < 8) begin
                total += 1;
                if (rb !== 1'b0 || ovb !== 1'b1 || tagb !== 4'h1 || resb !== 32'h40000000 || sent != 3) begin
                    bad += 1;
                    $display("FAIL bp_stall cycle %0d: got ready=%b v=%b tag=%h res=%h accepted=%0d, want 0 1 1 40000000 3",
                             c, rb, ovb, tagb, resb, sent);
                end
            end
            if (ovb === 1'b1 && orb) begin
                total += 1;
                if (got >= 5 || tagb !== 4'(got + 1) || resb !== bv[(got < 5) ? got : 0] || flb !== 4'h0) begin
                    bad += 1;
                    $display("FAIL bp_out #%0d: got tag=%h res=%h flags=%b, want tag=%h res=%h flags=0000",
                             got, tagb, resb, flb, 4'(got + 1), bv[(got < 5) ? got : 0]);
                end
                got += 1;
            end
            @(posedge clk);
            if (vb && rdy) sent += 1;
        end
        vb = 0;
        total += 1;
        if (got != 5 || sent != 5) begin
            bad += 1;
            $display("FAIL bp_count: got %0d results from %0d accepted, want 5 from 5", got, sent);
        end
    endtask

    task automatic test_reset_midflight;
        int seen = 0;
        orb = 1;
        @(negedge clk);
        vb = 1; ab = 32'h3F800000; bb = 32'h40000000; tb = 4'h7;
        @(negedge clk);
        tb = 4'h8;
        @(negedge clk);
        vb = 0; rst = 1;
        if (ovb === 1'b1) seen += 1;
        @(negedge clk);
        rst = 0;
        total += 1;
        if (rb !== 1'b1 || ovb !== 1'b0) begin
            bad += 1;
            $display("FAIL rst_mid_after: got ready=%b valid=%b, want 1 0", rb, ovb);
        end
        for (int c = 0; c < 8; c++) begin
            @(negedge clk);
            if (ovb !== 1'b0) seen += 1;
        end
        total += 1;
        if (seen != 0) begin
            bad += 1;
            $display("FAIL rst_mid_flush: got %0d valid cycles for discarded ops, want 0", seen);
        end
    endtask

    task automatic test_fp16;
        logic [15:0] va [2] = '{16'h3E00, 16'h7BFF};
        logic [15:0] vr [2] = '{16'h4200, 16'h7C00};
        logic [3:0]  vf [2] = '{4'b0000, 4'b0101};
        logic [15:0] res;
        logic [3:0]  fl;
        bit          lat_ok;
        for (int i = 0; i < 2; i++) begin
            issue16(va[i], 16'h4000, res, fl, lat_ok);
            total += 1;
            if (!lat_ok) begin
                bad += 1;
                $display("FAIL fp16[%0d] latency: result not valid 1 cycle after accept", i);
            end
            total += 1;
            if (res !== vr[i] || fl !== vf[i]) begin
                bad += 1;
                $display("FAIL fp16[%0d]: got %h flags %b, want %h flags %b", i, res, fl, vr[i], vf[i]);
            end
        end
    endtask

    initial begin
        repeat (3) @(posedge clk);
        @(negedge clk);
        rst = 0;
        test_reset();
        test_basics();
        test_rounding();
        test_exceptions();
        test_back_to_back();
        test_backpressure();
        test_reset_midflight();
        test_fp16();
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL timeout: bench did not finish, want completion");
        $fatal(1, "timeout");
    end

endmodule
